// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and the decoded-instruction record for the RV32I ALU issue stage.
// OP codes match the execute ALU's operation encoding.
package alu_issue_stage_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_AUIPC = 4'b1000;
    localparam logic [3:0] OP_JAL   = 4'b1001;
    localparam logic [3:0] OP_SRL   = 4'b1010;
    localparam logic [3:0] OP_SLT   = 4'b1100;
    localparam logic [3:0] OP_LUI   = 4'b1101;
    localparam logic [3:0] OP_BNE   = 4'b1110;
    localparam logic [3:0] OP_BGEU  = 4'b1111;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_write;
        logic        is_branch;
        logic        branch_inv;
        logic        is_jump;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } issue_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Purely combinational RV32I decode: instruction word, pc and register data into ALU
// operands, OP code and the side-band control bits carried to later stages.
module alu_issue_stage_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output issue_t      dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic        writes_rd;
    logic        bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = sext12(instr[31:20]);
    assign imm_s  = sext12({instr[31:25], instr[11:7]});
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Field decode; any unsupported encoding collapses to a clean illegal record at the end.
    always_comb begin
        dec       = '0;
        writes_rd = 1'b0;
        bad       = 1'b0;
        dec.rd    = instr[11:7];
        dec.a     = rs1_data;
        case (opcode)
            OPC_OP: begin
                dec.b     = rs2_data;
                writes_rd = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec.op = OP_ADD;
                    {F7_ALT,  3'b000}: dec.op = OP_SUB;
                    {F7_BASE, 3'b001}: begin dec.op = OP_SLL; dec.b = {27'd0, rs2_data[4:0]}; end
                    {F7_BASE, 3'b010}: dec.op = OP_SLT;
                    {F7_BASE, 3'b011}: dec.op = OP_SLTU;
                    {F7_BASE, 3'b100}: dec.op = OP_XOR;
                    {F7_BASE, 3'b101}: begin dec.op = OP_SRL; dec.b = {27'd0, rs2_data[4:0]}; end
                    {F7_ALT,  3'b101}: begin dec.op = OP_SRA; dec.b = {27'd0, rs2_data[4:0]}; end
                    {F7_BASE, 3'b110}: dec.op = OP_OR;
                    {F7_BASE, 3'b111}: dec.op = OP_AND;
                    default:           bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.b     = imm_i;
                dec.imm   = imm_i;
                writes_rd = 1'b1;
                case (funct3)
                    3'b000: dec.op = OP_ADD;
                    3'b010: dec.op = OP_SLT;
                    3'b011: dec.op = OP_SLTU;
                    3'b100: dec.op = OP_XOR;
                    3'b110: dec.op = OP_OR;
                    3'b111: dec.op = OP_AND;
                    3'b001: begin
                        dec.op = OP_SLL;
                        dec.b  = {27'd0, instr[24:20]};
                        if (funct7 == F7_BASE) bad = 1'b0;
                        else                   bad = 1'b1;
                    end
                    3'b101: begin
                        dec.b = {27'd0, instr[24:20]};
                        if (funct7 == F7_BASE)     dec.op = OP_SRL;
                        else if (funct7 == F7_ALT) dec.op = OP_SRA;
                        else                       bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.b     = imm_i;
                dec.imm   = imm_i;
                writes_rd = 1'b1;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec.mem_rd = 1'b1;
                    default:                                bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.b   = imm_s;
                dec.imm = imm_s;
                case (funct3)
                    3'b000, 3'b001, 3'b010: dec.mem_wr = 1'b1;
                    default:                bad = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                // taken = ALU carry-out XOR branch_inv in execute
                dec.b         = rs2_data;
                dec.imm       = imm_b;
                dec.is_branch = 1'b1;
                case (funct3)
                    3'b000:  dec.op = OP_ADD;
                    3'b001:  dec.op = OP_BNE;
                    3'b100:  dec.op = OP_SLT;
                    3'b101:  begin dec.op = OP_SLT;  dec.branch_inv = 1'b1; end
                    3'b110:  begin dec.op = OP_BGEU; dec.branch_inv = 1'b1; end
                    3'b111:  dec.op = OP_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec.a       = pc;
                dec.b       = imm_j;
                dec.imm     = imm_j;
                dec.op      = OP_JAL;
                dec.is_jump = 1'b1;
                writes_rd   = 1'b1;
            end
            OPC_JALR: begin
                dec.b       = imm_i;
                dec.imm     = imm_i;
                dec.is_jump = 1'b1;
                writes_rd   = 1'b1;
                if (funct3 == 3'b000) bad = 1'b0;
                else                  bad = 1'b1;
            end
            OPC_LUI: begin
                dec.a     = {12'd0, instr[31:12]};
                dec.b     = 32'd0;
                dec.imm   = {instr[31:12], 12'd0};
                dec.op    = OP_LUI;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a     = pc;
                dec.b     = {12'd0, instr[31:12]};
                dec.imm   = {instr[31:12], 12'd0};
                dec.op    = OP_AUIPC;
                writes_rd = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end else begin
            dec.reg_write = writes_rd && (dec.rd != 5'd0);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the RV32I execute ALU: decode plus a single-entry pipeline
// register with valid/ready handshake and flush.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            is_branch,
    output logic            branch_inv,
    output logic            is_jump,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            illegal
);

    issue_t dec;
    issue_t held;

    alu_issue_stage_decode u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec)
    );

    assign in_ready = !out_valid || out_ready;

    // Pipeline register: flush beats accept; a consume and an accept on one edge reload directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            held      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                held <= dec;
            end
        end
    end

    assign alu_a      = held.a;
    assign alu_b      = held.b;
    assign alu_op     = held.op;
    assign imm        = held.imm;
    assign rd         = held.rd;
    assign reg_write  = held.reg_write;
    assign is_branch  = held.is_branch;
    assign branch_inv = held.branch_inv;
    assign is_jump    = held.is_jump;
    assign mem_rd     = held.mem_rd;
    assign mem_wr     = held.mem_wr;
    assign illegal    = held.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage with hand-computed decode results,
// plus stall, flush and reset sequences.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        branch_inv;
    logic        is_jump;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .imm        (imm),
        .rd         (rd),
        .reg_write  (reg_write),
        .is_branch  (is_branch),
        .branch_inv (branch_inv),
        .is_jump    (is_jump),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [111:0] exp;
    } vec_t;

    vec_t vecs[17];
    int   checks = 0;
    int   fails  = 0;

    // flags order: reg_write, is_branch, branch_inv, is_jump, mem_rd, mem_wr, illegal
    function automatic logic [111:0] pack(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic [31:0] im,
                                          input logic [4:0] r, input logic [6:0] flags);
        return {a, b, op, im, r, flags};
    endfunction

    logic [111:0] act;
    assign act = {alu_a, alu_b, alu_op, imm, rd,
                  reg_write, is_branch, branch_inv, is_jump, mem_rd, mem_wr, illegal};

    task automatic check(input string name, input logic [111:0] got, input logic [111:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        check(name, {111'd0, got}, {111'd0, want});
    endtask

    task automatic drive(input vec_t v, input logic valid);
        instr    = v.instr;
        pc       = v.pc;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
        in_valid = valid;
    endtask

    initial begin
        vecs[0]  = '{"addi_m1",  32'hFFF08293, 32'h1000, 32'h10,       32'h0,
                     pack(32'h10, 32'hFFFFFFFF, 4'h0, 32'hFFFFFFFF, 5'd5, 7'b1000000)};
        vecs[1]  = '{"srai",     32'h40415193, 32'h1000, 32'h80000000, 32'h0,
                     pack(32'h80000000, 32'h4, 4'h7, 32'h00000404, 5'd3, 7'b1000000)};
        vecs[2]  = '{"lui",      32'h123453B7, 32'h1000, 32'h0,        32'h0,
                     pack(32'h00012345, 32'h0, 4'hD, 32'h12345000, 5'd7, 7'b1000000)};
        vecs[3]  = '{"bge",      32'h0020D463, 32'h1000, 32'h5,        32'h6,
                     pack(32'h5, 32'h6, 4'hC, 32'h8, 5'd8, 7'b0110000)};
        vecs[4]  = '{"sub",      32'h403100B3, 32'h1000, 32'h50,       32'h20,
                     pack(32'h50, 32'h20, 4'h1, 32'h0, 5'd1, 7'b1000000)};
        vecs[5]  = '{"sll",      32'h00629233, 32'h1000, 32'h1,        32'hFFFFFF25,
                     pack(32'h1, 32'h5, 4'h5, 32'h0, 5'd4, 7'b1000000)};
        vecs[6]  = '{"auipc",    32'hABCDE517, 32'h1000, 32'h0,        32'h0,
                     pack(32'h1000, 32'h000ABCDE, 4'h8, 32'hABCDE000, 5'd10, 7'b1000000)};
        vecs[7]  = '{"lw",       32'hFFC12583, 32'h1000, 32'h2000,     32'h0,
                     pack(32'h2000, 32'hFFFFFFFC, 4'h0, 32'hFFFFFFFC, 5'd11, 7'b1000100)};
        vecs[8]  = '{"sw",       32'h00322423, 32'h1000, 32'h3000,     32'hDEAD,
                     pack(32'h3000, 32'h8, 4'h0, 32'h8, 5'd8, 7'b0000010)};
        vecs[9]  = '{"jal",      32'h010000EF, 32'h1000, 32'h0,        32'h0,
                     pack(32'h1000, 32'h10, 4'h9, 32'h10, 5'd1, 7'b1001000)};
        vecs[10] = '{"jalr_x0",  32'h00008067, 32'h1000, 32'h4444,     32'h0,
                     pack(32'h4444, 32'h0, 4'h0, 32'h0, 5'd0, 7'b0001000)};
        vecs[11] = '{"bltu",     32'hFE20EEE3, 32'h1000, 32'h7,        32'h9,
                     pack(32'h7, 32'h9, 4'hF, 32'hFFFFFFFC, 5'd29, 7'b0110000)};
        vecs[12] = '{"ill_7f",   32'h0000007F, 32'h1000, 32'h1234,     32'h5678,
                     pack(32'h0, 32'h0, 4'h0, 32'h0, 5'd0, 7'b0000001)};
        vecs[13] = '{"addi_x0",  32'h00500013, 32'h1000, 32'h77,       32'h0,
                     pack(32'h77, 32'h5, 4'h0, 32'h5, 5'd0, 7'b0000000)};
        vecs[14] = '{"sltiu",    32'h0011B113, 32'h1000, 32'h0,        32'h0,
                     pack(32'h0, 32'h1, 4'h4, 32'h1, 5'd2, 7'b1000000)};
        vecs[15] = '{"ill_mul",  32'h02000033, 32'h1000, 32'h9,        32'h9,
                     pack(32'h0, 32'h0, 4'h0, 32'h0, 5'd0, 7'b0000001)};
        vecs[16] = '{"bne",      32'h00209463, 32'h1000, 32'h1,        32'h2,
                     pack(32'h1, 32'h2, 4'hE, 32'h8, 5'd8, 7'b0100000)};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(vecs[0], 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_out_valid", out_valid, 1'b0);
        check("reset_outputs", act, 112'd0);
        check_bit("reset_in_ready", in_ready, 1'b1);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i], 1'b1);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_valid"}, {111'd0, out_valid}, 112'd1);
            check(vecs[i].name, act, vecs[i].exp);
        end

        // no new input while execute consumes: bubble
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_bit("bubble_out_valid", out_valid, 1'b0);

        // stall three cycles with a pending instruction, then consume + reload
        @(negedge clk);
        drive(vecs[0], 1'b1);
        @(posedge clk);
        #1;
        check("stall_load", act, vecs[0].exp);
        @(negedge clk);
        drive(vecs[2], 1'b1);
        out_ready = 1'b0;
        #1;
        check_bit("stall_in_ready_comb", in_ready, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("stall_hold", act, vecs[0].exp);
            check_bit("stall_valid", out_valid, 1'b1);
            check_bit("stall_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_bit("release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("release_reload", act, vecs[2].exp);
        check_bit("release_valid", out_valid, 1'b1);

        // flush while stalled with a new instruction offered
        @(negedge clk);
        drive(vecs[3], 1'b1);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("flush_pre_hold", act, vecs[2].exp);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check_bit("flush_out_valid", out_valid, 1'b0);
        check_bit("flush_in_ready", in_ready, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        drive(vecs[4], 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_flush_load", act, vecs[4].exp);

        // reset in the middle of a stall
        @(negedge clk);
        drive(vecs[5], 1'b1);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pre_hold", act, vecs[4].exp);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_bit("rst_stall_valid", out_valid, 1'b0);
        check("rst_stall_outputs", act, 112'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
